// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, default opcodes and the IR
// capture pattern used by the IR/DR chain.
package jtag_pkg;

   localparam int unsigned TAP_STATE_W = 4;

   // TAP controller state encoding as presented by the controller
   localparam logic [TAP_STATE_W-1:0] TLR    = 4'd0;
   localparam logic [TAP_STATE_W-1:0] RTI    = 4'd1;
   localparam logic [TAP_STATE_W-1:0] SEL_DR = 4'd2;
   localparam logic [TAP_STATE_W-1:0] CAP_DR = 4'd3;
   localparam logic [TAP_STATE_W-1:0] SH_DR  = 4'd4;
   localparam logic [TAP_STATE_W-1:0] EX1_DR = 4'd5;
   localparam logic [TAP_STATE_W-1:0] PAU_DR = 4'd6;
   localparam logic [TAP_STATE_W-1:0] EX2_DR = 4'd7;
   localparam logic [TAP_STATE_W-1:0] UPD_DR = 4'd8;
   localparam logic [TAP_STATE_W-1:0] SEL_IR = 4'd9;
   localparam logic [TAP_STATE_W-1:0] CAP_IR = 4'd10;
   localparam logic [TAP_STATE_W-1:0] SH_IR  = 4'd11;
   localparam logic [TAP_STATE_W-1:0] EX1_IR = 4'd12;
   localparam logic [TAP_STATE_W-1:0] PAU_IR = 4'd13;
   localparam logic [TAP_STATE_W-1:0] EX2_IR = 4'd14;
   localparam logic [TAP_STATE_W-1:0] UPD_IR = 4'd15;

   // Default opcodes for a 4-bit IR; BYPASS is all ones
   localparam logic [3:0] DEF_INSTR_IDCODE = 4'h1;
   localparam logic [3:0] DEF_INSTR_USER   = 4'h2;
   localparam logic [3:0] DEF_INSTR_BYPASS = 4'hF;

   // Value loaded into the IR shift register LSBs at CAPTURE_IR
   localparam logic [1:0] IR_CAPTURE = 2'b01;

   // Default IDCODE capture value
   localparam logic [31:0] DEF_IDCODE_VAL = 32'h4BA0_0477;

endpackage

// File: rtl/jtag_ir_dr_chain_if.sv
// Bundle between the TAP controller / debug logic and the IR/DR chain.
//   state, tdi, user_capture_data : driven by the controller side (master)
//   tdo, tdo_en, ir, user_sel,
//   user_update_data, user_update : driven by the chain (slave)
interface jtag_ir_dr_chain_if #(
   parameter int unsigned IR_W   = 4,
   parameter int unsigned USER_W = 8
);
   logic [3:0]        state;
   logic              tdi;
   logic              tdo;
   logic              tdo_en;
   logic [IR_W-1:0]   ir;
   logic              user_sel;
   logic [USER_W-1:0] user_capture_data;
   logic [USER_W-1:0] user_update_data;
   logic              user_update;

   modport master (
      output state, tdi, user_capture_data,
      input  tdo, tdo_en, ir, user_sel, user_update_data, user_update
   );

   modport slave (
      input  state, tdi, user_capture_data,
      output tdo, tdo_en, ir, user_sel, user_update_data, user_update
   );
endinterface

// File: rtl/jtag_shift_reg.sv
// Generic JTAG shift register: synchronous clear, parallel capture and
// right shift with serial input at the MSB. Serial output is q[0].
//   CLK, RESET : clock, async active-high reset
//   clr        : synchronous clear (Test-Logic-Reset)
//   cap        : load ld_val
//   shift      : shift right, si enters at MSB
//   q          : register contents
module jtag_shift_reg #(
   parameter int unsigned W = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         clr,
   input  logic         cap,
   input  logic         shift,
   input  logic [W-1:0] ld_val,
   input  logic         si,
   output logic [W-1:0] q
);

   logic [W-1:0] sh_nxt;

   // Shifted value; written this way so W == 1 needs no special case
   always_comb begin
      sh_nxt        = q >> 1;
      sh_nxt[W-1]   = si;
   end

   // Priority: clear, capture, shift, otherwise hold
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (cap) begin
         q <= ld_val;
      end else if (shift) begin
         q <= sh_nxt;
      end
   end

endmodule

// File: rtl/jtag_ir_dr_chain.sv
// JTAG instruction register and data registers (BYPASS, IDCODE, USER)
// driven by the TAP state from the controller, in the TCK domain.
//   CLK   : TCK
//   RESET : async active-high reset
//   bus   : slave side of jtag_ir_dr_chain_if (state/tdi/user_capture_data
//           in; tdo/tdo_en/ir/user_sel/user_update_data/user_update out)
// tdo, tdo_en and user_sel are combinational; everything else is registered.
module jtag_ir_dr_chain
   import jtag_pkg::*;
#(
   parameter int unsigned     IR_W         = 4,
   parameter logic [31:0]     IDCODE_VAL   = DEF_IDCODE_VAL,
   parameter int unsigned     USER_W       = 8,
   parameter logic [IR_W-1:0] INSTR_IDCODE = IR_W'(DEF_INSTR_IDCODE),
   parameter logic [IR_W-1:0] INSTR_USER   = IR_W'(DEF_INSTR_USER)
) (
   input logic               CLK,
   input logic               RESET,
   jtag_ir_dr_chain_if.slave bus
);

   localparam int unsigned IDCODE_W = 32;

   // TAP state decodes
   logic st_tlr;
   logic st_cap_ir;
   logic st_sh_ir;
   logic st_upd_ir;
   logic st_cap_dr;
   logic st_sh_dr;
   logic st_upd_dr;

   assign st_tlr    = (bus.state == TLR);
   assign st_cap_ir = (bus.state == CAP_IR);
   assign st_sh_ir  = (bus.state == SH_IR);
   assign st_upd_ir = (bus.state == UPD_IR);
   assign st_cap_dr = (bus.state == CAP_DR);
   assign st_sh_dr  = (bus.state == SH_DR);
   assign st_upd_dr = (bus.state == UPD_DR);

   logic [IR_W-1:0]     ir_q;
   logic [IR_W-1:0]     ir_sr;
   logic [IDCODE_W-1:0] id_sr;
   logic [USER_W-1:0]   user_sr;
   logic                byp_q;
   logic [USER_W-1:0]   user_upd_q;
   logic                user_upd_pls_q;

   // Instruction decode; any opcode other than IDCODE/USER selects BYPASS
   logic sel_idcode;
   logic sel_user;
   logic sel_bypass;

   assign sel_idcode = (ir_q == INSTR_IDCODE);
   assign sel_user   = (ir_q == INSTR_USER);
   assign sel_bypass = !sel_idcode && !sel_user;

   // Instruction shift register, captures ...01 at CAPTURE_IR
   jtag_shift_reg #(.W(IR_W)) u_ir_sr (
      .CLK    (CLK),
      .RESET  (RESET),
      .clr    (st_tlr),
      .cap    (st_cap_ir),
      .shift  (st_sh_ir),
      .ld_val (IR_W'(IR_CAPTURE)),
      .si     (bus.tdi),
      .q      (ir_sr)
   );

   // IDCODE data register
   jtag_shift_reg #(.W(IDCODE_W)) u_id_sr (
      .CLK    (CLK),
      .RESET  (RESET),
      .clr    (st_tlr),
      .cap    (st_cap_dr && sel_idcode),
      .shift  (st_sh_dr && sel_idcode),
      .ld_val (IDCODE_VAL),
      .si     (bus.tdi),
      .q      (id_sr)
   );

   // USER data register
   jtag_shift_reg #(.W(USER_W)) u_user_sr (
      .CLK    (CLK),
      .RESET  (RESET),
      .clr    (st_tlr),
      .cap    (st_cap_dr && sel_user),
      .shift  (st_sh_dr && sel_user),
      .ld_val (bus.user_capture_data),
      .si     (bus.tdi),
      .q      (user_sr)
   );

   // BYPASS register: single flop, captures 0
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         byp_q <= 1'b0;
      end else if (st_tlr) begin
         byp_q <= 1'b0;
      end else if (st_cap_dr && sel_bypass) begin
         byp_q <= 1'b0;
      end else if (st_sh_dr && sel_bypass) begin
         byp_q <= bus.tdi;
      end
   end

   // Latched instruction; only UPDATE_IR changes it, so DR scans see a stable ir
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ir_q <= INSTR_IDCODE;
      end else if (st_tlr) begin
         ir_q <= INSTR_IDCODE;
      end else if (st_upd_ir) begin
         ir_q <= ir_sr;
      end
   end

   // USER update latch and one-cycle strobe
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         user_upd_q     <= '0;
         user_upd_pls_q <= 1'b0;
      end else begin
         user_upd_pls_q <= 1'b0;
         if (st_tlr) begin
            user_upd_q <= '0;
         end else if (st_upd_dr && sel_user) begin
            user_upd_q     <= user_sr;
            user_upd_pls_q <= 1'b1;
         end
      end
   end

   // Serial output mux: LSB of whichever register is currently shifting
   logic tdo_c;

   always_comb begin
      tdo_c = 1'b0;
      if (st_sh_ir) begin
         tdo_c = ir_sr[0];
      end else if (st_sh_dr) begin
         if (sel_idcode) begin
            tdo_c = id_sr[0];
         end else if (sel_user) begin
            tdo_c = user_sr[0];
         end else begin
            tdo_c = byp_q;
         end
      end
   end

   assign bus.tdo              = tdo_c;
   assign bus.tdo_en           = st_sh_ir || st_sh_dr;
   assign bus.ir               = ir_q;
   assign bus.user_sel         = sel_user;
   assign bus.user_update_data = user_upd_q;
   assign bus.user_update      = user_upd_pls_q;

endmodule

// File: tb/tb_jtag_ir_dr_chain.sv
// Self-checking bench for jtag_ir_dr_chain: directed table, hand-written
// corner sequences and a random TAP walk against a queue-based model.
module tb_jtag_ir_dr_chain;
   import jtag_pkg::*;

   localparam logic [31:0] IDC = 32'h4BA0_0477;

   logic CLK;
   logic RESET;

   jtag_ir_dr_chain_if #(.IR_W(4), .USER_W(8)) bus ();

   jtag_ir_dr_chain dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int errors = 0;
   int checks = 0;
   bit s_tdo;
   bit s_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One TCK cycle: drive state/tdi, sample comb outputs, then pass the edge
   task automatic cyc(input logic [3:0] st, input bit t);
      bus.state = st;
      bus.tdi   = t;
      #2;
      s_tdo = bus.tdo;
      s_en  = bus.tdo_en;
      @(posedge CLK);
      #1;
   endtask

   task automatic load_ir(input logic [3:0] op);
      cyc(SEL_DR, 1'b0);
      cyc(SEL_IR, 1'b0);
      cyc(CAP_IR, 1'b0);
      for (int i = 0; i < 4; i++) cyc(SH_IR, op[i]);
      cyc(EX1_IR, 1'b0);
      cyc(UPD_IR, 1'b0);
      cyc(RTI, 1'b0);
   endtask

   task automatic dr_shift(input int n, input logic [31:0] din, output logic [31:0] dout);
      dout = '0;
      for (int i = 0; i < n; i++) begin
         cyc(SH_DR, din[i]);
         dout[i] = s_tdo;
      end
   endtask

   // ---------------- behavioural model: registers as bit queues, LSB at front
   typedef bit bq_t[$];
   bq_t mq_ir, mq_id, mq_user, mq_byp;
   int  m_ir;
   int  m_ud;
   bit  m_uu;

   function automatic bq_t mkq(input logic [31:0] v, input int w);
      bq_t q;
      q = {};
      for (int i = 0; i < w; i++) q.push_back(v[i]);
      return q;
   endfunction

   function automatic int qval(input bq_t q);
      int v;
      v = 0;
      foreach (q[i]) if (q[i]) v = v | (1 << i);
      return v;
   endfunction

   function automatic void model_reset();
      m_ir    = 1;
      mq_ir   = mkq(0, 4);
      mq_id   = mkq(0, 32);
      mq_user = mkq(0, 8);
      mq_byp  = mkq(0, 1);
      m_ud    = 0;
      m_uu    = 0;
   endfunction

   function automatic bit model_tdo(input logic [3:0] st);
      if (st == SH_IR) return mq_ir[0];
      if (st == SH_DR) begin
         if (m_ir == 1) return mq_id[0];
         if (m_ir == 2) return mq_user[0];
         return mq_byp[0];
      end
      return 1'b0;
   endfunction

   function automatic void model_step(input logic [3:0] st, input bit t, input logic [7:0] ucd);
      m_uu = 0;
      case (st)
         TLR:    model_reset();
         CAP_IR: mq_ir = mkq(1, 4);
         SH_IR:  begin void'(mq_ir.pop_front()); mq_ir.push_back(t); end
         UPD_IR: m_ir = qval(mq_ir);
         CAP_DR: begin
            if (m_ir == 1)      mq_id   = mkq(IDC, 32);
            else if (m_ir == 2) mq_user = mkq(32'(ucd), 8);
            else                mq_byp  = mkq(0, 1);
         end
         SH_DR: begin
            if (m_ir == 1)      begin void'(mq_id.pop_front());   mq_id.push_back(t);   end
            else if (m_ir == 2) begin void'(mq_user.pop_front()); mq_user.push_back(t); end
            else                begin void'(mq_byp.pop_front());  mq_byp.push_back(t);  end
         end
         UPD_DR: if (m_ir == 2) begin m_ud = qval(mq_user); m_uu = 1; end
         default: ;
      endcase
   endfunction

   // Standard TAP transitions, used to produce legal random state walks
   function automatic logic [3:0] tap_next(input logic [3:0] st, input bit tms);
      case (st)
         TLR:    return tms ? TLR    : RTI;
         RTI:    return tms ? SEL_DR : RTI;
         SEL_DR: return tms ? SEL_IR : CAP_DR;
         CAP_DR: return tms ? EX1_DR : SH_DR;
         SH_DR:  return tms ? EX1_DR : SH_DR;
         EX1_DR: return tms ? UPD_DR : PAU_DR;
         PAU_DR: return tms ? EX2_DR : PAU_DR;
         EX2_DR: return tms ? UPD_DR : SH_DR;
         UPD_DR: return tms ? SEL_DR : RTI;
         SEL_IR: return tms ? TLR    : CAP_IR;
         CAP_IR: return tms ? EX1_IR : SH_IR;
         SH_IR:  return tms ? EX1_IR : SH_IR;
         EX1_IR: return tms ? UPD_IR : PAU_IR;
         PAU_IR: return tms ? EX2_IR : PAU_IR;
         EX2_IR: return tms ? UPD_IR : SH_IR;
         default: return tms ? SEL_DR : RTI;
      endcase
   endfunction

   // ---------------- directed table
   typedef struct {
      logic [3:0] st;
      bit         tdi;
      bit         exp_tdo;
      bit         exp_en;
      logic [3:0] exp_ir;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [31:0] dout;
      logic [31:0] d2;
      bit          en_all;
      logic [3:0]  st;
      logic [3:0]  tgt;
      logic [7:0]  ucd;
      bit          t;
      bit          tms;
      bit          e_tdo;
      int          ir_cnt;

      // Test-plan 2 sequence: IR scan to BYPASS, then a bypass DR scan
      tbl.push_back('{SEL_DR, 1'b0, 1'b0, 1'b0, 4'h1});
      tbl.push_back('{SEL_IR, 1'b0, 1'b0, 1'b0, 4'h1});
      tbl.push_back('{CAP_IR, 1'b0, 1'b0, 1'b0, 4'h1});
      tbl.push_back('{SH_IR,  1'b1, 1'b1, 1'b1, 4'h1});
      tbl.push_back('{SH_IR,  1'b1, 1'b0, 1'b1, 4'h1});
      tbl.push_back('{SH_IR,  1'b1, 1'b0, 1'b1, 4'h1});
      tbl.push_back('{SH_IR,  1'b1, 1'b0, 1'b1, 4'h1});
      tbl.push_back('{EX1_IR, 1'b0, 1'b0, 1'b0, 4'h1});
      tbl.push_back('{UPD_IR, 1'b0, 1'b0, 1'b0, 4'hF});
      tbl.push_back('{SEL_DR, 1'b0, 1'b0, 1'b0, 4'hF});
      tbl.push_back('{CAP_DR, 1'b0, 1'b0, 1'b0, 4'hF});
      tbl.push_back('{SH_DR,  1'b1, 1'b0, 1'b1, 4'hF});
      tbl.push_back('{SH_DR,  1'b0, 1'b1, 1'b1, 4'hF});
      tbl.push_back('{SH_DR,  1'b1, 1'b0, 1'b1, 4'hF});
      tbl.push_back('{SH_DR,  1'b1, 1'b1, 1'b1, 4'hF});
      tbl.push_back('{EX1_DR, 1'b0, 1'b0, 1'b0, 4'hF});
      tbl.push_back('{UPD_DR, 1'b0, 1'b0, 1'b0, 4'hF});
      tbl.push_back('{RTI,    1'b0, 1'b0, 1'b0, 4'hF});

      // Reset values
      RESET = 1'b1;
      bus.state = TLR;
      bus.tdi = 1'b0;
      bus.user_capture_data = 8'h00;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      chk("reset ir", 32'(bus.ir), 32'h1);
      chk("reset user_update_data", 32'(bus.user_update_data), 32'h0);
      chk("reset user_update", 32'(bus.user_update), 32'h0);
      chk("reset user_sel", 32'(bus.user_sel), 32'h0);
      chk("reset tdo", 32'(bus.tdo), 32'h0);
      RESET = 1'b0;

      // 1: IDCODE shift-out
      cyc(TLR, 1'b0);
      cyc(RTI, 1'b0);
      cyc(SEL_DR, 1'b0);
      cyc(CAP_DR, 1'b0);
      en_all = 1'b1;
      dout = '0;
      for (int i = 0; i < 32; i++) begin
         cyc(SH_DR, 1'b0);
         dout[i] = s_tdo;
         en_all = en_all & s_en;
      end
      chk("t1 idcode", dout, IDC);
      chk("t1 tdo_en", 32'(en_all), 32'h1);
      cyc(EX1_DR, 1'b0);
      cyc(UPD_DR, 1'b0);
      chk("t1 no user_update", 32'(bus.user_update), 32'h0);
      cyc(RTI, 1'b0);

      // 2: table
      foreach (tbl[i]) begin
         cyc(tbl[i].st, tbl[i].tdi);
         chk($sformatf("t2 row%0d tdo", i), 32'(s_tdo), 32'(tbl[i].exp_tdo));
         chk($sformatf("t2 row%0d tdo_en", i), 32'(s_en), 32'(tbl[i].exp_en));
         chk($sformatf("t2 row%0d ir", i), 32'(bus.ir), 32'(tbl[i].exp_ir));
      end

      // 3: USER capture/shift/update
      bus.user_capture_data = 8'hA5;
      load_ir(4'h2);
      chk("t3 ir", 32'(bus.ir), 32'h2);
      chk("t3 user_sel", 32'(bus.user_sel), 32'h1);
      cyc(SEL_DR, 1'b0);
      cyc(CAP_DR, 1'b0);
      dr_shift(8, 32'h3C, dout);
      chk("t3 tdo", dout, 32'hA5);
      cyc(EX1_DR, 1'b0);
      chk("t3 user_update pre", 32'(bus.user_update), 32'h0);
      cyc(UPD_DR, 1'b0);
      chk("t3 user_update", 32'(bus.user_update), 32'h1);
      chk("t3 user_update_data", 32'(bus.user_update_data), 32'h3C);
      cyc(RTI, 1'b0);
      chk("t3 user_update post", 32'(bus.user_update), 32'h0);

      // 4: USER scan split by a pause; capture input changes must not reload
      bus.user_capture_data = 8'h5A;
      cyc(SEL_DR, 1'b0);
      cyc(CAP_DR, 1'b0);
      bus.user_capture_data = 8'hFF;
      dr_shift(4, 32'h3, dout);
      cyc(EX1_DR, 1'b0);
      for (int i = 0; i < 3; i++) cyc(PAU_DR, 1'b1);
      cyc(EX2_DR, 1'b1);
      dr_shift(4, 32'hC, d2);
      chk("t4 tdo", {d2[3:0], dout[3:0]}, 32'h5A);
      cyc(EX1_DR, 1'b0);
      cyc(UPD_DR, 1'b0);
      chk("t4 user_update_data", 32'(bus.user_update_data), 32'hC3);
      chk("t4 user_update", 32'(bus.user_update), 32'h1);
      cyc(RTI, 1'b0);

      // 5a: one TLR cycle restores defaults
      cyc(TLR, 1'b0);
      chk("t5 tlr ir", 32'(bus.ir), 32'h1);
      chk("t5 tlr user_update_data", 32'(bus.user_update_data), 32'h0);
      chk("t5 tlr user_sel", 32'(bus.user_sel), 32'h0);

      // 5b: async RESET in the middle of a USER shift
      cyc(RTI, 1'b0);
      bus.user_capture_data = 8'hFF;
      load_ir(4'h2);
      cyc(SEL_DR, 1'b0);
      cyc(CAP_DR, 1'b0);
      cyc(SH_DR, 1'b1);
      cyc(SH_DR, 1'b0);
      bus.state = SH_DR;
      #2;
      RESET = 1'b1;
      #1;
      chk("t5 async ir", 32'(bus.ir), 32'h1);
      chk("t5 async tdo", 32'(bus.tdo), 32'h0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      cyc(TLR, 1'b0);
      cyc(RTI, 1'b0);

      // 6: unlisted opcode acts as BYPASS
      load_ir(4'h7);
      chk("t6 ir", 32'(bus.ir), 32'h7);
      chk("t6 user_sel", 32'(bus.user_sel), 32'h0);
      cyc(SEL_DR, 1'b0);
      cyc(CAP_DR, 1'b0);
      dr_shift(4, 32'hD, dout);
      chk("t6 bypass tdo", dout, 32'hA);
      cyc(EX1_DR, 1'b0);
      cyc(UPD_DR, 1'b0);
      chk("t6 user_update", 32'(bus.user_update), 32'h0);
      chk("t6 user_update_data", 32'(bus.user_update_data), 32'h0);
      cyc(RTI, 1'b0);

      // Random TAP walk against the model
      RESET = 1'b1;
      #3;
      RESET = 1'b0;
      model_reset();
      st = TLR;
      tgt = 4'h2;
      ir_cnt = 0;
      for (int n = 0; n < 1500; n++) begin
         ucd = 8'($urandom);
         bus.user_capture_data = ucd;
         if (st == CAP_IR) begin
            case ($urandom_range(0, 5))
               0: tgt = 4'h1;
               1, 2: tgt = 4'h2;
               3: tgt = 4'hF;
               4: tgt = 4'h7;
               default: tgt = 4'($urandom);
            endcase
            ir_cnt = 0;
         end
         if (st == SH_IR) begin
            t = tgt[ir_cnt % 4];
            ir_cnt++;
         end else begin
            t = 1'($urandom);
         end
         e_tdo = model_tdo(st);
         cyc(st, t);
         chk("rnd tdo", 32'(s_tdo), 32'(e_tdo));
         chk("rnd tdo_en", 32'(s_en), 32'((st == SH_DR) || (st == SH_IR)));
         model_step(st, t, ucd);
         chk("rnd ir", 32'(bus.ir), 32'(m_ir));
         chk("rnd user_sel", 32'(bus.user_sel), 32'(m_ir == 2));
         chk("rnd user_update", 32'(bus.user_update), 32'(m_uu));
         chk("rnd user_update_data", 32'(bus.user_update_data), 32'(m_ud));
         if (st == SH_DR || st == SH_IR || st == PAU_DR || st == PAU_IR)
            tms = ($urandom_range(0, 5) == 0);
         else if (st == SEL_IR)
            tms = ($urandom_range(0, 7) == 0);
         else
            tms = 1'($urandom);
         st = tap_next(st, tms);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
